hazard_forward_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order pipeline. It generalises the fixed

---
 rtl/hazard_forward_if.sv | 49 ++++
 rtl/hazard_forward_unit.sv | 134 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hazard_forward_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_if
//   Bundles the decode-side request, pipeline result data and the control /
//   forwarding responses exchanged with hazard_forward_unit.
//   master : decode/pipeline side (drives instruction info and data, reads
//            enables, forwarding selects, operands and the stall counter)
//   slave  : the hazard/forwarding unit itself
// ---------------------------------------------------------------------------
interface hazard_forward_if #(
  parameter int XLEN           = 64,
  parameter int REGISTER_SIZE  = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int PIPE_DEPTH     = 3,
  parameter int STALL_CNT_W    = 16
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  logic                                    dec_valid;
  logic [NUM_READ_PORTS*REGISTER_SIZE-1:0] dec_rs_addr;
  logic [NUM_READ_PORTS-1:0]               dec_rs_used;
  logic [REGISTER_SIZE-1:0]                dec_rd_addr;
  logic                                    dec_rd_write;
  logic                                    dec_rd_is_load;
  logic                                    ex_busy;
  logic                                    flush;
  logic [NUM_READ_PORTS*XLEN-1:0]          rf_data;
  logic [PIPE_DEPTH*XLEN-1:0]              stage_data;

  logic                                    f_to_d_enable;
  logic                                    d_to_e_enable;
  logic                                    d_to_e_bubble;
  logic [NUM_READ_PORTS*SEL_W-1:0]         fwd_sel;
  logic [NUM_READ_PORTS*XLEN-1:0]          operand;
  logic [STALL_CNT_W-1:0]                  stall_count;

  modport master (
    output dec_valid, dec_rs_addr, dec_rs_used, dec_rd_addr, dec_rd_write,
           dec_rd_is_load, ex_busy, flush, rf_data, stage_data,
    input  f_to_d_enable, d_to_e_enable, d_to_e_bubble, fwd_sel, operand,
           stall_count
  );

  modport slave (
    input  dec_valid, dec_rs_addr, dec_rs_used, dec_rd_addr, dec_rd_write,
           dec_rd_is_load, ex_busy, flush, rf_data, stage_data,
    output f_to_d_enable, d_to_e_enable, d_to_e_bubble, fwd_sel, operand,
           stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//   Hazard detection and operand forwarding for the in-order pipeline.
//   Tracks the destination register of every instruction in the PIPE_DEPTH
//   stages after decode (0=EX ... PIPE_DEPTH-1=WB), selects the youngest
//   in-flight producer for each decode source operand, detects load-use
//   hazards, and arbitrates the F->D / D->E enables against multi-cycle
//   execute ops and redirects.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     hf (slave) : decode request, RF/stage data in; enables, bubble,
//                  fwd_sel (0=RF, k=stage k-1), operand, stall_count out
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int XLEN           = 64,
  parameter int REGISTER_SIZE  = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int PIPE_DEPTH     = 3,
  parameter int LOAD_STAGE     = 1,
  parameter int STALL_CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  hazard_forward_if.slave hf
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  // Scoreboard: valid is control (reset), rd/is_load are payload (no reset).
  logic                     ent_vld [PIPE_DEPTH];
  logic [REGISTER_SIZE-1:0] ent_rd  [PIPE_DEPTH];
  logic                     ent_ld  [PIPE_DEPTH];

  logic [STALL_CNT_W-1:0]            stall_cnt;
  logic [NUM_READ_PORTS-1:0]         port_haz;
  logic [NUM_READ_PORTS*SEL_W-1:0]   sel_vec;
  logic [NUM_READ_PORTS*XLEN-1:0]    op_vec;
  logic                              load_use;
  logic                              f_to_d;
  logic                              d_to_e;
  logic                              bubble;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Per-port match: the loop runs oldest to youngest so the youngest
  // producer overwrites older ones. x0 is hard-wired and never forwarded.
  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic [REGISTER_SIZE-1:0] rs;
    logic [SEL_W-1:0]         sel;
    logic                     haz;
    logic [XLEN-1:0]          op;

    assign rs = hf.dec_rs_addr[p*REGISTER_SIZE +: REGISTER_SIZE];

    always_comb begin
      sel = '0;
      haz = 1'b0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (hf.dec_rs_used[p] && ent_vld[k] && (ent_rd[k] == rs) && (rs != '0)) begin
          sel = SEL_W'(k + 1);
          // Only the youngest match decides: a younger ALU write shadows an older load.
          haz = ent_ld[k] && (k < LOAD_STAGE);
        end
      end
    end

    always_comb begin
      op = hf.rf_data[p*XLEN +: XLEN];
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        if (sel == SEL_W'(k + 1)) op = hf.stage_data[k*XLEN +: XLEN];
      end
    end

    assign sel_vec[p*SEL_W +: SEL_W] = sel;
    assign op_vec[p*XLEN +: XLEN]    = op;
    assign port_haz[p]               = haz;
  end

  assign load_use = hf.dec_valid && (|port_haz);

  // ex_busy freezes D->E; a concurrent flush still lets fetch advance because
  // the held decode instruction is dropped by the refetch.
  always_comb begin
    f_to_d = 1'b1;
    d_to_e = 1'b1;
    bubble = 1'b0;
    if (hf.ex_busy) begin
      f_to_d = hf.flush;
      d_to_e = 1'b0;
    end else if (hf.flush) begin
      bubble = 1'b1;
    end else if (load_use) begin
      f_to_d = 1'b0;
      bubble = 1'b1;
    end
  end

  // ---- stage boundary: decode -> EX, EX -> MEM ... -> WB (control) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) ent_vld[k] <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!hf.ex_busy) begin
        ent_vld[0] <= !(bubble || !hf.dec_valid || !hf.dec_rd_write);
        ent_vld[1] <= ent_vld[0];
      end else begin
        ent_vld[1] <= 1'b0;
      end
      for (int k = 2; k < PIPE_DEPTH; k++) ent_vld[k] <= ent_vld[k-1];
      if (!f_to_d) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // ---- stage boundary: decode -> EX, EX -> MEM ... -> WB (payload) ----
  always_ff @(posedge clk) begin
    if (!hf.ex_busy) begin
      ent_rd[0] <= hf.dec_rd_addr;
      ent_ld[0] <= hf.dec_rd_is_load;
    end
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      ent_rd[k] <= ent_rd[k-1];
      ent_ld[k] <= ent_ld[k-1];
    end
  end

  assign hf.f_to_d_enable = f_to_d;
  assign hf.d_to_e_enable = d_to_e;
  assign hf.d_to_e_bubble = bubble;
  assign hf.fwd_sel       = sel_vec;
  assign hf.operand       = op_vec;
  assign hf.stall_count   = stall_cnt;
endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
  localparam int XLEN = 64;
  localparam int RS   = 5;
  localparam int NRP  = 2;
  localparam int PD   = 3;
  localparam int LS   = 1;
  localparam int SCW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_if #(.XLEN(XLEN), .REGISTER_SIZE(RS), .NUM_READ_PORTS(NRP),
                      .PIPE_DEPTH(PD), .STALL_CNT_W(SCW)) hf ();

  hazard_forward_unit #(.XLEN(XLEN), .REGISTER_SIZE(RS), .NUM_READ_PORTS(NRP),
                        .PIPE_DEPTH(PD), .LOAD_STAGE(LS), .STALL_CNT_W(SCW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hf    (hf)
  );

  typedef struct {
    int dv, rs0, rs1, used, rd, wr, ld, fl;
    int f2d, d2e, bub, s0, s1, sc;
  } vec_t;

  vec_t vecs [13];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [63:0] rf_val(int p);
    return 64'hAAAA_0000_0000_0000 + 64'(p);
  endfunction

  function automatic logic [63:0] st_val(int k);
    return 64'h5555_0000_0000_0100 + 64'(k);
  endfunction

  function automatic logic [63:0] exp_op(int p, int sel);
    return (sel == 0) ? rf_val(p) : st_val(sel - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(int dv, int rs0, int rs1, int used, int rd, int wr, int ld, int busy, int fl);
    hf.dec_valid      = 1'(dv);
    hf.dec_rs_addr    = {5'(rs1), 5'(rs0)};
    hf.dec_rs_used    = 2'(used);
    hf.dec_rd_addr    = 5'(rd);
    hf.dec_rd_write   = 1'(wr);
    hf.dec_rd_is_load = 1'(ld);
    hf.ex_busy        = 1'(busy);
    hf.flush          = 1'(fl);
  endtask

  task automatic chk_ctl(input string tag, int f2d, int d2e, int bub, int s0, int s1, int sc);
    chk({tag, ".f2d"}, 64'(hf.f_to_d_enable), 64'(f2d));
    chk({tag, ".d2e"}, 64'(hf.d_to_e_enable), 64'(d2e));
    chk({tag, ".bub"}, 64'(hf.d_to_e_bubble), 64'(bub));
    chk({tag, ".sel0"}, 64'(hf.fwd_sel[1:0]), 64'(s0));
    chk({tag, ".sel1"}, 64'(hf.fwd_sel[3:2]), 64'(s1));
    chk({tag, ".op0"}, hf.operand[63:0], exp_op(0, s0));
    chk({tag, ".op1"}, hf.operand[127:64], exp_op(1, s1));
    chk({tag, ".stall"}, 64'(hf.stall_count), 64'(sc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           dv rs0 rs1 used rd wr ld fl   f2d d2e bub s0 s1 sc
    vecs[0]  = '{1, 1,  2,  3,   5, 1, 0, 0,   1,  1,  0,  0, 0, 0};
    vecs[1]  = '{1, 5,  7,  3,   6, 1, 1, 0,   1,  1,  0,  1, 0, 0};
    vecs[2]  = '{1, 6,  5,  3,   8, 1, 0, 0,   0,  1,  1,  1, 2, 0};
    vecs[3]  = '{1, 6,  5,  3,   8, 1, 0, 0,   1,  1,  0,  2, 3, 1};
    vecs[4]  = '{1, 8,  6,  3,   9, 1, 0, 0,   1,  1,  0,  1, 3, 1};
    vecs[5]  = '{1, 9,  9,  3,   9, 1, 0, 0,   1,  1,  0,  1, 1, 1};
    vecs[6]  = '{1, 9,  8,  3,   0, 1, 0, 0,   1,  1,  0,  1, 3, 1};
    vecs[7]  = '{1, 0,  9,  3,   3, 0, 0, 0,   1,  1,  0,  0, 2, 1};
    vecs[8]  = '{1, 9,  9,  2,   4, 1, 1, 0,   1,  1,  0,  0, 3, 1};
    vecs[9]  = '{0, 4,  4,  3,   7, 1, 0, 0,   1,  1,  0,  1, 1, 1};
    vecs[10] = '{1, 4,  0,  3,  10, 1, 1, 0,   1,  1,  0,  2, 0, 1};
    vecs[11] = '{1, 10, 4,  3,  11, 1, 0, 1,   1,  1,  1,  1, 3, 1};
    vecs[12] = '{1, 10, 10, 3,  12, 1, 0, 0,   1,  1,  0,  2, 2, 1};

    hf.rf_data    = {rf_val(1), rf_val(0)};
    hf.stage_data = {st_val(2), st_val(1), st_val(0)};
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    chk_ctl("reset", 1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].dv, vecs[i].rs0, vecs[i].rs1, vecs[i].used, vecs[i].rd,
            vecs[i].wr, vecs[i].ld, 0, vecs[i].fl);
      @(negedge clk);
      chk_ctl($sformatf("v%0d", i), vecs[i].f2d, vecs[i].d2e, vecs[i].bub,
              vecs[i].s0, vecs[i].s1, vecs[i].sc);
    end

    // ex_busy for 3 cycles, flush on the second
    @(posedge clk); #1; drive(1, 0, 0, 0, 13, 1, 0, 0, 0);
    @(posedge clk); #1; drive(1, 13, 12, 3, 14, 1, 0, 1, 0);
    @(negedge clk); chk_ctl("busy1", 0, 0, 0, 1, 2, 1);
    @(posedge clk); #1; drive(1, 13, 12, 3, 14, 1, 0, 1, 1);
    @(negedge clk); chk_ctl("busy2", 1, 0, 0, 1, 3, 2);
    @(posedge clk); #1; drive(1, 13, 12, 3, 14, 1, 0, 1, 0);
    @(negedge clk); chk_ctl("busy3", 0, 0, 0, 1, 0, 2);
    @(posedge clk); #1; drive(0, 13, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk_ctl("unbusy", 1, 1, 0, 1, 0, 3);
    @(posedge clk); #1;
    @(negedge clk); chk_ctl("held_to_mem", 1, 1, 0, 2, 0, 3);

    // Async reset in the middle of a load-use stall
    @(posedge clk); #1; drive(1, 0, 0, 0, 20, 1, 1, 0, 0);
    @(posedge clk); #1; drive(1, 20, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk_ctl("lu_pre_rst", 0, 1, 1, 1, 0, 3);
    #2 rst_n = 1'b0;
    #1 chk_ctl("async_rst", 1, 1, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk); chk_ctl("rst_next", 1, 1, 0, 0, 0, 0);

    // Stall counter saturation with a 4-bit counter
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b1;
    #1 chk("sat.f2d", 64'(hf.f_to_d_enable), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d", i), 64'(hf.stall_count), 64'((i > 15) ? 15 : i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
